fft_input_framer: RTL and testbench
===================================

# fft_input_framer

Serial-to-parallel front end for the 8-point FFT pipeline. Accepts one Q5.7 time-domain sample per handshake, assembles 8-sample frames in a ping-pong buffer and presents each complete frame in parallel to the stage-1 butterfly with a single-cycle enable pulse. It holds the frame until stage 1 reports completion, so the next frame can fill without stalling the source.

## Interface
- FFT_N, 8: samples per frame; fixed, matches the stage-1 butterfly width.
- SW, 12: sample width, signed Q5.7.
- CLK  in  1  system clock, rising edge.
- nRESET  in  1  reset: asynchronous, active-low.
- s_valid  in  1  source has a sample on s_data.
- s_ready  out  1  framer can accept a sample this cycle.
- s_data  in  SW  signed Q5.7 time-domain sample.
- frame_out[0:7]  out  SW each  parallel frame to stage 1; index 0 = earliest sample.
- fft_enable  out  1  one-cycle strobe; frame_out is valid and stable in this cycle.
- stage1_done  in  1  completion pulse from stage 1.
- busy  out  1  a frame is presented and stage1_done is not yet seen.
- frame_count  out  8  frames issued, modulo 256.

## Operation
- Two banks, each FFT_N x SW. Exactly one is the write bank and one is the read bank; the bank select bit flips on swap.
- Write side: wr_idx counts 0..7 and wr_full is a flag. A sample is accepted when s_valid && s_ready, stored at the write bank at wr_idx, and wr_idx increments. Accepting index 7 sets wr_full. s_ready = !wr_full.
- Read side FSM:
  - IDLE: if wr_full, or if the 8th sample is accepted in this cycle, then swap banks, clear wr_full and wr_idx, go to FIRE.
  - FIRE: fft_enable=1 for exactly one cycle; frame_count++; go to WAIT.
  - WAIT: busy=1. On stage1_done go to IDLE. stage1_done sampled in IDLE or FIRE is ignored.
- frame_out always drives the read bank. The read bank is never written while in FIRE or WAIT.
- Backpressure: if the write bank is full while the FSM is in FIRE or WAIT, s_ready=0 until the swap.
- Simultaneous stage1_done in WAIT and 8th-sample acceptance: go to IDLE, then swap on the next edge. This adds one cycle, with no data loss.
- Reset: all outputs 0 (frame_out all 0, fft_enable 0, busy 0, frame_count 0). s_ready=1 after reset. Banks cleared, wr_idx=0, FSM=IDLE, bank select=0. A partial frame in progress at reset is discarded.

## Timing
- Back-to-back input: the 8th sample is accepted at edge t. Swap happens at edge t if the FSM is IDLE. fft_enable is high in cycle t..t+1, and frame_out is valid from edge t.
- The source sees no stall during a swap. s_ready stays 1 through the swap edge, and the sample at edge t+1 goes to slot 0 of the new write bank.
- Steady state, with stage1_done one cycle after fft_enable: one frame per 8 accepted samples, s_ready is continuously 1.
- frame_out changes only on a swap edge.

## Configuration
- FFT_FRAMER_HANN_EN defined:
  - Each sample is multiplied by the 8-point Hann coefficient for its slot before storage.
  - Coefficients are unsigned Q1.7: 0, 19, 64, 109, 128, 109, 64, 19.
  - Full product is 20 bits, arithmetic >>7, truncated to 12 bits. Cannot overflow, since coefficient ≤ 1.0.
  - Adds no latency: the multiply is combinational on the write path.
- Undefined: samples are stored unmodified; no multiplier is present.

## Structure
- Package fft_pkg holds:
  - sample_t (logic signed [11:0]);
  - FFT_N;
  - HANN_COEF[0:7] localparam array;
  - the read FSM state enum {IDLE, FIRE, WAIT}.
- Sub-module fft_frame_bank: one FFT_N x SW register bank with write enable, write index, write data and parallel read-out, asynchronously reset to 0. Instantiated twice; the top-level muxes the read bank onto frame_out.

## Test plan
- Reset mid-fill: after 5 samples, pulse nRESET low. Required: all outputs 0, s_ready=1. The next 8 samples 1..8 produce frame_out = 1..8 (macro off).
- Single frame, macro off: feed 12'sd1..12'sd8 back-to-back with stage1_done one cycle after fft_enable. Required: one fft_enable pulse in the cycle after the 8th acceptance, frame_out[i]=i+1, frame_count=1.
- Backpressure: hold stage1_done low and stream 20 samples. Required:
  - s_ready drops after the 16th acceptance;
  - frame 1 holds stable;
  - asserting stage1_done releases frame 2 (samples 9..16) with one fft_enable;
  - s_ready returns to 1.
- Simultaneous events: assert stage1_done on the same edge the 8th sample of the next frame is accepted. Required: fft_enable follows 2 cycles later, with no sample lost or duplicated.
- Streaming: 2048 random samples with continuous s_valid and a prompt stage1_done. Required:
  - s_ready never deasserts;
  - 256 fft_enable pulses;
  - frame_count wraps to 0;
  - every frame matches the scoreboard.
- Macro on: feed a constant 12'sd128 (1.0). Required: frame_out = 0, 19, 64, 109, 128, 109, 64, 19.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT input framer.
// The Hann table and helper are only referenced when FFT_FRAMER_HANN_EN is defined.
package fft_pkg;

    localparam int FFT_N = 8;
    localparam int SW    = 12;
    localparam int IDX_W = $clog2(FFT_N);

    typedef logic signed [SW-1:0] sample_t;

    // 8-point Hann window, unsigned Q1.7
    localparam logic [7:0] HANN_COEF [0:FFT_N-1] = '{
        8'd0, 8'd19, 8'd64, 8'd109, 8'd128, 8'd109, 8'd64, 8'd19
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } rd_state_t;

    // Coefficient never exceeds 1.0, so the scaled result always fits back in SW bits.
    function automatic sample_t hann_window(input sample_t x, input logic [IDX_W-1:0] slot);
        logic signed [19:0] prod;
        prod = 20'(x) * 20'($signed({1'b0, HANN_COEF[slot]}));
        return sample_t'(prod >>> 7);
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One FFT_N x SW frame register bank: indexed write port, full parallel read-out.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  sample_t          wr_data,
    output sample_t          rd_data [0:FFT_N-1]
);

    sample_t mem [0:FFT_N-1];

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < FFT_N; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem;

endmodule

// File: rtl/fft_input_framer.sv
// Serial-to-parallel ping-pong framer feeding the 8-point FFT stage-1 butterfly.
// Optional Hann windowing on the write path when FFT_FRAMER_HANN_EN is defined.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no frame outstanding; swap banks as soon as the write bank fills
//   FIRE  | fft_enable strobe cycle for the freshly swapped read bank
//   WAIT  | frame held for stage 1 until stage1_done
module fft_input_framer
    import fft_pkg::*;
(
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        s_valid,
    output logic        s_ready,
    input  sample_t     s_data,
    output sample_t     frame_out [0:FFT_N-1],
    output logic        fft_enable,
    input  logic        stage1_done,
    output logic        busy,
    output logic [7:0]  frame_count
);

    rd_state_t        state;
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_full;
    logic             accept;
    logic             last_accept;
    logic             swap;
    sample_t          wr_data;
    sample_t          bank0_q [0:FFT_N-1];
    sample_t          bank1_q [0:FFT_N-1];

    assign s_ready     = !wr_full;
    assign accept      = s_valid && s_ready;
    assign last_accept = accept && (wr_idx == IDX_W'(FFT_N - 1));
    // Swapping on the filling edge itself keeps s_ready high through the swap.
    assign swap        = (state == IDLE) && (wr_full || last_accept);

`ifdef FFT_FRAMER_HANN_EN
    assign wr_data = hann_window(s_data, wr_idx);
`else
    assign wr_data = s_data;
`endif

    fft_frame_bank u_bank0 (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .wr_en   (accept && !wr_bank),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_data (bank0_q)
    );

    fft_frame_bank u_bank1 (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .wr_en   (accept && wr_bank),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_data (bank1_q)
    );

    // Read bank is always the one not being written.
    always_comb begin
        for (int i = 0; i < FFT_N; i++) begin
            frame_out[i] = wr_bank ? bank0_q[i] : bank1_q[i];
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            wr_full <= 1'b0;
        end else if (swap) begin
            wr_bank <= ~wr_bank;
            wr_idx  <= '0;
            wr_full <= 1'b0;
        end else if (accept) begin
            wr_idx <= wr_idx + IDX_W'(1);
            if (last_accept) begin
                wr_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state       <= IDLE;
            fft_enable  <= 1'b0;
            busy        <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    fft_enable <= 1'b0;
                    busy       <= 1'b0;
                    if (swap) begin
                        state       <= FIRE;
                        fft_enable  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                    end
                end
                FIRE: begin
                    state      <= WAIT;
                    fft_enable <= 1'b0;
                    busy       <= 1'b1;
                end
                WAIT: begin
                    fft_enable <= 1'b0;
                    if (stage1_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    fft_enable <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed and scoreboarded bench for fft_input_framer (FFT_FRAMER_HANN_EN selects the windowed model).
module tb_fft_input_framer;
    import fft_pkg::*;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    sample_t    s_data = '0;
    sample_t    frame_out [0:FFT_N-1];
    logic       fft_enable;
    logic       stage1_done;
    logic       busy;
    logic [7:0] frame_count;

    logic done_man  = 1'b0;
    logic done_auto = 1'b0;
    logic auto_done = 1'b0;
    logic stream_mode = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int ready_drops = 0;
    int exp_q[$];
    int acc[$];
    int base;

    assign stage1_done = done_man | done_auto;

    always #5 CLK = ~CLK;

    fft_input_framer dut (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .frame_out   (frame_out),
        .fft_enable  (fft_enable),
        .stage1_done (stage1_done),
        .busy        (busy),
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model(input int v, input int slot);
`ifdef FFT_FRAMER_HANN_EN
        int coef [0:7] = '{0, 19, 64, 109, 128, 109, 64, 19};
        return (v * coef[slot]) >>> 7;
`else
        return v + 0 * slot;
`endif
    endfunction

    task automatic note_accept(input int v);
        acc.push_back(model(v, acc.size()));
        if (acc.size() == FFT_N) begin
            foreach (acc[i]) exp_q.push_back(acc[i]);
            acc.delete();
        end
    endtask

    // Present v and return at the negedge before the edge that accepts it.
    task automatic send(input int v);
        bit ok = 0;
        @(posedge CLK); #1;
        s_valid = 1'b1;
        s_data  = sample_t'(v);
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) note_accept(v);
        else check("send_ready_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        @(posedge CLK); #1;
        s_valid = 1'b0;
        repeat (n) @(posedge CLK);
    endtask

    task automatic wait_enable(input string tag, input int target);
        for (int k = 0; k < 100; k++) begin
            if (en_cnt >= target) break;
            @(negedge CLK); #1;
        end
        check(tag, en_cnt, target);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        s_valid = 1'b0;
        nRESET  = 1'b0;
        acc.delete();
        exp_q.delete();
        @(negedge CLK);
        check("rst_ready", s_ready, 1);
        check("rst_enable", fft_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_count", frame_count, 0);
        for (int i = 0; i < FFT_N; i++) check("rst_frame", frame_out[i], 0);
        @(posedge CLK); #1;
        nRESET = 1'b1;
    endtask

    // Scoreboard: every fft_enable frame against the accepted-sample model.
    initial begin
        forever begin
            @(negedge CLK);
            if (stream_mode && !s_ready) ready_drops++;
            if (fft_enable) begin
                en_cnt++;
                if (exp_q.size() >= FFT_N) begin
                    for (int i = 0; i < FFT_N; i++) check("sb_frame", frame_out[i], exp_q.pop_front());
                end else begin
                    check("sb_frame_avail", exp_q.size(), FFT_N);
                end
            end
        end
    end

    // Stage-1 model: completion one cycle after the enable strobe.
    initial begin
        forever begin
            @(negedge CLK);
            if (auto_done && fft_enable) begin
                @(posedge CLK); #1 done_auto = 1'b1;
                @(posedge CLK); #1 done_auto = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // power-on reset
        repeat (2) @(negedge CLK);
        check("por_ready", s_ready, 1);
        check("por_enable", fft_enable, 0);
        check("por_busy", busy, 0);
        check("por_count", frame_count, 0);
        check("por_frame0", frame_out[0], 0);
        @(posedge CLK); #1 nRESET = 1'b1;

        // single frame 1..8
        auto_done = 1'b1;
        for (int v = 1; v <= 8; v++) send(v);
        @(posedge CLK); #1 s_valid = 1'b0;
        @(negedge CLK);
        check("t1_enable", fft_enable, 1);
        check("t1_count", frame_count, 1);
        for (int i = 0; i < FFT_N; i++) check("t1_frame", frame_out[i], model(i + 1, i));
        @(negedge CLK);
        check("t1_enable_off", fft_enable, 0);
        check("t1_busy", busy, 1);
        repeat (3) @(negedge CLK);
        check("t1_busy_off", busy, 0);

        // reset mid-fill discards the partial frame
        for (int v = 50; v < 55; v++) send(v);
        do_reset();
        base = en_cnt;
        for (int v = 1; v <= 8; v++) send(v);
        idle(1);
        wait_enable("t2_enables", base + 1);
        for (int i = 0; i < FFT_N; i++) check("t2_frame", frame_out[i], model(i + 1, i));
        check("t2_count", frame_count, 1);
        idle(4);

        // backpressure with stage1_done held low
        auto_done = 1'b0;
        base = en_cnt;
        for (int v = 201; v <= 216; v++) send(v);
        fork
            begin
                repeat (5) @(negedge CLK);
                check("bp_ready_low", s_ready, 0);
                check("bp_busy", busy, 1);
                check("bp_hold0", frame_out[0], model(201, 0));
                check("bp_hold7", frame_out[7], model(208, 7));
                check("bp_one_enable", en_cnt, base + 1);
                @(posedge CLK); #1 done_man = 1'b1;
                @(posedge CLK); #1 done_man = 1'b0;
                auto_done = 1'b1;
            end
            send(217);
        join
        wait_enable("bp_release", base + 2);
        check("bp_frame2_0", frame_out[0], model(209, 0));
        check("bp_frame2_7", frame_out[7], model(216, 7));
        check("bp_ready_back", s_ready, 1);
        for (int v = 218; v <= 224; v++) send(v);
        idle(1);
        wait_enable("bp_frame3", base + 3);
        idle(4);

        // stage1_done on the same edge as the 8th sample
        auto_done = 1'b0;
        base = en_cnt;
        for (int v = 301; v <= 315; v++) send(v);
        @(posedge CLK); #1;
        s_data = sample_t'(316);
        done_man = 1'b1;
        check("sim_ready", s_ready, 1);
        note_accept(316);
        @(posedge CLK); #1;
        done_man = 1'b0;
        s_valid = 1'b0;
        auto_done = 1'b1;
        @(negedge CLK);
        check("sim_gap_enable", fft_enable, 0);
        check("sim_gap_ready", s_ready, 0);
        @(negedge CLK);
        check("sim_enable", fft_enable, 1);
        check("sim_frame0", frame_out[0], model(309, 0));
        check("sim_frame7", frame_out[7], model(316, 7));
        #1;
        check("sim_enables", en_cnt, base + 2);
        idle(4);
        check("count_before_stream", frame_count, 6);

        // streaming: 2048 random samples, prompt completion
        do_reset();
        auto_done = 1'b1;
        stream_mode = 1'b1;
        base = en_cnt;
        for (int n = 0; n < 2048; n++) begin
            int r;
            r = int'($urandom_range(0, 4095));
            send(r >= 2048 ? r - 4096 : r);
        end
        idle(1);
        wait_enable("stream_enables", base + 256);
        idle(4);
        stream_mode = 1'b0;
        check("stream_ready_drops", ready_drops, 0);
        check("stream_count_wrap", frame_count, 0);
        check("stream_leftover", exp_q.size(), 0);

`ifdef FFT_FRAMER_HANN_EN
        begin
            int hann [0:7] = '{0, 19, 64, 109, 128, 109, 64, 19};
            base = en_cnt;
            for (int i = 0; i < FFT_N; i++) send(128);
            idle(1);
            wait_enable("hann_enable", base + 1);
            for (int i = 0; i < FFT_N; i++) check("hann_frame", frame_out[i], hann[i]);
            idle(4);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
